// File: rtl/gray_pkg.sv
//------------------------------------------------------------------------------
// Module      : gray_pkg
// Description : Shared mode encodings, skid-stage state type and Gray/binary
//               conversion helpers for the Gray<->binary pipeline.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Helpers work on a wide word; callers zero-extend and truncate, which is
    // exact for both directions because high zero bits contribute nothing.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_skid_buffer.sv
//------------------------------------------------------------------------------
// Module      : gray_skid_buffer
// Description : Two-entry elastic stage (output register plus one skid entry)
//               with a registered in_ready.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_skid_buffer
    import gray_pkg::*;
#(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_e   state_q, state_d;
    logic [DW-1:0] out_q, out_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          accept;
    logic          xfer;

    assign accept    = in_valid & in_ready_q;
    assign xfer      = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    out_d   = in_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && !xfer) begin
                    skid_d  = in_data;
                    state_d = SKID_TWO;
                end else if (!accept && xfer) begin
                    state_d = SKID_EMPTY;
                end else if (accept && xfer) begin
                    out_d   = in_data;
                end
            end
            SKID_TWO: begin
                if (xfer) begin
                    out_d   = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        // Flags are registered from the next state so neither output has a
        // combinational path from out_ready.
        in_ready_d  = (state_d != SKID_TWO);
        out_valid_d = (state_d != SKID_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gray_bin_converter_pipe.sv
//------------------------------------------------------------------------------
// Module      : gray_bin_converter_pipe
// Description : Registered Gray<->binary converter with valid/ready streams,
//               Gray adjacency monitoring and a saturating error counter.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_bin_converter_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             adj_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int PC_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] prev_g_q, prev_g_d;
    logic             prev_vld_q, prev_vld_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] diff;
    logic [PC_W-1:0]  ones;
    logic             is_g2b;
    logic             accept;
    logic             beat_err;
    logic [WIDTH+1:0] skid_in;
    logic [WIDTH+1:0] skid_out;

    assign is_g2b = (in_mode == MODE_G2B);
    assign accept = in_valid & in_ready;
    assign diff   = prev_g_q ^ in_data;

    assign conv = (in_mode == MODE_B2G) ? WIDTH'(bin2gray(MAX_W'(in_data)))
                                        : WIDTH'(gray2bin(MAX_W'(in_data)));

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + PC_W'(diff[i]);
        end
    end

    // A clear in the same cycle forgets the history before this beat is judged.
    assign beat_err = is_g2b & prev_vld_q & ~clr_err & (ones != PC_W'(1));

    always_comb begin
        prev_g_d    = prev_g_q;
        prev_vld_d  = prev_vld_q;
        err_count_d = err_count_q;
        if (accept && is_g2b) begin
            prev_g_d   = in_data;
            prev_vld_d = 1'b1;
        end else if (clr_err) begin
            prev_vld_d = 1'b0;
        end
        if (clr_err) begin
            err_count_d = '0;
        end else if (accept && beat_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_g_q    <= '0;
            prev_vld_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            prev_g_q    <= prev_g_d;
            prev_vld_q  <= prev_vld_d;
            err_count_q <= err_count_d;
        end
    end

    assign skid_in   = {beat_err, in_mode, conv};
    assign err_count = err_count_q;
    assign {adj_err, out_mode, out_data} = skid_out;

    gray_skid_buffer #(
        .DW (WIDTH + 2)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (skid_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_gray_bin_converter_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_gray_bin_converter_pipe
// Description : Self-checking bench for gray_bin_converter_pipe (3-bit and
//               8-bit instances).
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gray_bin_converter_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 3-bit instance with a 2-bit counter
    logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
    logic       a_out_mode, a_adj_err, a_clr_err;
    logic [2:0] a_in_data, a_out_data;
    logic [1:0] a_err_count;

    // 8-bit instance with an 8-bit counter
    logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
    logic       b_out_mode, b_adj_err, b_clr_err;
    logic [7:0] b_in_data, b_out_data;
    logic [7:0] b_err_count;

    gray_bin_converter_pipe #(.WIDTH(3), .CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_mode(a_out_mode), .adj_err(a_adj_err), .clr_err(a_clr_err), .err_count(a_err_count)
    );

    gray_bin_converter_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_mode(b_out_mode), .adj_err(b_adj_err), .clr_err(b_clr_err), .err_count(b_err_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [2:0] din;
        logic       mode;
        logic [2:0] exp_out;
        logic       exp_err;
    } vec_t;

    vec_t vec [20];

    typedef struct {
        logic [7:0] d;
        logic       m;
        logic       e;
    } beat_t;

    beat_t      q[$];
    logic [7:0] inv_gray [256];
    logic [7:0] m_prev;
    logic       m_prev_vld;
    int         m_cnt;

    initial begin
        // G2B sweep: Gray codes in counting order decode to 0..7
        vec[0]  = '{3'b000, 1'b0, 3'd0, 1'b0};
        vec[1]  = '{3'b001, 1'b0, 3'd1, 1'b0};
        vec[2]  = '{3'b011, 1'b0, 3'd2, 1'b0};
        vec[3]  = '{3'b010, 1'b0, 3'd3, 1'b0};
        vec[4]  = '{3'b110, 1'b0, 3'd4, 1'b0};
        vec[5]  = '{3'b111, 1'b0, 3'd5, 1'b0};
        vec[6]  = '{3'b101, 1'b0, 3'd6, 1'b0};
        vec[7]  = '{3'b100, 1'b0, 3'd7, 1'b0};
        // B2G sweep
        vec[8]  = '{3'd0, 1'b1, 3'b000, 1'b0};
        vec[9]  = '{3'd1, 1'b1, 3'b001, 1'b0};
        vec[10] = '{3'd2, 1'b1, 3'b011, 1'b0};
        vec[11] = '{3'd3, 1'b1, 3'b010, 1'b0};
        vec[12] = '{3'd4, 1'b1, 3'b110, 1'b0};
        vec[13] = '{3'd5, 1'b1, 3'b111, 1'b0};
        vec[14] = '{3'd6, 1'b1, 3'b101, 1'b0};
        vec[15] = '{3'd7, 1'b1, 3'b100, 1'b0};
        // Adjacency: history is 100 from the G2B sweep
        vec[16] = '{3'b000, 1'b0, 3'b000, 1'b0};
        vec[17] = '{3'b011, 1'b0, 3'b010, 1'b1};
        vec[18] = '{3'b011, 1'b0, 3'b010, 1'b1};
        vec[19] = '{3'b010, 1'b0, 3'b011, 1'b0};

        for (int b = 0; b < 256; b++) inv_gray[8'(b ^ (b >> 1))] = 8'(b);

        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_in_mode = 0; a_out_ready = 1; a_clr_err = 0;
        b_in_valid = 0; b_in_data = '0; b_in_mode = 0; b_out_ready = 1; b_clr_err = 0;
        #12;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_mode", a_out_mode, 0);
        chk("rst_adj_err", a_adj_err, 0);
        chk("rst_err_count", a_err_count, 0);
        chk("rst_in_ready", a_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tables: sweeps and adjacency errors
        for (int i = 0; i < 20; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = vec[i].din;
            a_in_mode  = vec[i].mode;
            step();
            chk($sformatf("vec%0d_valid", i), a_out_valid, 1);
            chk($sformatf("vec%0d_data", i), a_out_data, vec[i].exp_out);
            chk($sformatf("vec%0d_mode", i), a_out_mode, vec[i].mode);
            chk($sformatf("vec%0d_err", i), a_adj_err, vec[i].exp_err);
            if (i == 15) chk("sweep_err_count", a_err_count, 0);
        end
        chk("adj_err_count", a_err_count, 2);
        a_in_valid = 1'b0;
        step();
        chk("drain_valid", a_out_valid, 0);

        // Backpressure: three B2G beats into a stalled sink
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_mode = 1'b1; a_in_data = 3'd1;
        step();
        chk("bp_ready1", a_in_ready, 1);
        a_in_data = 3'd2;
        step();
        chk("bp_ready2", a_in_ready, 0);
        a_in_data = 3'd3;
        step();
        chk("bp_held_ready", a_in_ready, 0);
        chk("bp_held_data", a_out_data, 3'b001);
        chk("bp_held_valid", a_out_valid, 1);
        a_out_ready = 1'b1;
        step();
        chk("bp_out2", a_out_data, 3'b011);
        chk("bp_ready_back", a_in_ready, 1);
        step();
        chk("bp_out3", a_out_data, 3'b010);
        chk("bp_err_count", a_err_count, 2);
        a_in_valid = 1'b0;
        step();
        chk("bp_empty", a_out_valid, 0);

        // Saturation and clear (2-bit counter)
        a_clr_err = 1'b1;
        step();
        a_clr_err = 1'b0;
        chk("clr_count", a_err_count, 0);
        a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 3'b000;
        step();
        chk("sat_first_err", a_adj_err, 0);
        for (int i = 0; i < 5; i++) begin
            a_in_data = (i % 2 == 0) ? 3'b011 : 3'b000;
            step();
            chk($sformatf("sat%0d_err", i), a_adj_err, 1);
            chk($sformatf("sat%0d_count", i), a_err_count, (i < 3) ? i + 1 : 3);
        end
        a_clr_err = 1'b1; a_in_data = 3'b011;
        step();
        a_clr_err = 1'b0;
        chk("clr_acc_err", a_adj_err, 0);
        chk("clr_acc_count", a_err_count, 0);
        step();
        chk("post_clr_err", a_adj_err, 1);
        chk("post_clr_count", a_err_count, 1);
        a_in_valid = 1'b0;

        // Reset with wide data and a full elastic stage
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = 8'h00;
        step();
        b_in_data = 8'hFF;
        step();
        b_in_valid = 1'b0;
        chk("full_ready", b_in_ready, 0);
        chk("full_count", b_err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", b_out_valid, 0);
        chk("arst_count", b_err_count, 0);
        chk("arst_ready", b_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = 8'hFF;
        step();
        b_in_valid = 1'b0;
        chk("wide_data", b_out_data, 8'hAA);
        chk("wide_err", b_adj_err, 0);

        // Randomised run against a queue-based model
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_prev = '0; m_prev_vld = 0; m_cnt = 0;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic acc, xf, g2b, e;
            chk("rnd_valid", b_out_valid, q.size() > 0);
            chk("rnd_ready", b_in_ready, q.size() < 2);
            chk("rnd_count", b_err_count, m_cnt);
            if (q.size() > 0 && b_out_valid) begin
                chk("rnd_data", b_out_data, q[0].d);
                chk("rnd_mode", b_out_mode, q[0].m);
                chk("rnd_err", b_adj_err, q[0].e);
            end
            // a beat offered but not accepted must be held
            if (!(b_in_valid && q.size() >= 2)) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in_mode  = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0, 1:    b_in_data = m_prev ^ (8'h01 << $urandom_range(0, 7));
                    2:       b_in_data = m_prev;
                    default: b_in_data = 8'($urandom);
                endcase
            end
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_clr_err   = ($urandom_range(0, 19) == 0) && !(b_in_valid && b_in_mode);

            acc = b_in_valid && (q.size() < 2);
            xf  = (q.size() > 0) && b_out_ready;
            g2b = !b_in_mode;
            e   = g2b && m_prev_vld && !b_clr_err && ($countones(m_prev ^ b_in_data) != 1);
            if (xf) void'(q.pop_front());
            if (acc) q.push_back('{b_in_mode ? (b_in_data ^ (b_in_data >> 1)) : inv_gray[b_in_data],
                                   b_in_mode, e});
            if (b_clr_err) m_cnt = 0;
            else if (acc && e && m_cnt < 255) m_cnt++;
            if (acc && g2b) begin
                m_prev = b_in_data;
                m_prev_vld = 1'b1;
            end else if (b_clr_err) begin
                m_prev_vld = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
